load_ou: RTL and testbench
==========================

LOAD_OU -- requirements
Module: load_ou

Interface
REQ-001 Parameter LOAD_WIDTH, default LW_BYTE: access size, one of LW_BYTE, LW_HALF or LW_WORD.
REQ-002 Parameter LOAD_SIGNED, default 0: 1 sign-extends the result, 0 zero-extends it; ignored for LW_WORD.
REQ-003 Parameter MAX_OUTSTANDING, default 4: in-flight load limit; power of 2, range 1..16.
REQ-004 Parameter ADDR_OFFSET, default 0: signed 12-bit constant added to data_in1 to form the address.
REQ-005 clk  in  1  clock; one clock domain, rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 data_in1  in  XLEN  base address; data_valid_in1  in  1  base address valid.
REQ-008 data_in2  in  XLEN  unused; data_valid_in2  in  1  unused.
REQ-009 data_in_ack1  out  1  base address consumed; data_in_ack2  out  1  tied 0.
REQ-010 uses_data_in1  out  1  tied 1; uses_data_in2  out  1  tied 0.
REQ-011 data_out  out  XLEN  extended load result; data_valid_out  out  1  one-cycle result strobe.
REQ-012 addr  out  XLEN  word-aligned address; data  out  XLEN  tied 0; fn3  out  3  tied LS_W_fn3.
REQ-013 load  out  1  tied 1; store  out  1  tied 0.
REQ-014 new_request  out  1  LSQ request strobe; lsq_full  in  1  LSQ cannot accept a request.
REQ-015 load_data  in  XLEN  raw aligned word returned by the LSQ; load_complete  in  1  load_data valid.

Function
REQ-016 Effective address: ea = data_in1 + sign-extended ADDR_OFFSET, wrapping modulo 2^XLEN.
REQ-017 addr: ea with bits [1:0] forced to 00.
REQ-018 Issue condition: issue = data_valid_in1 && !lsq_full && (count < MAX_OUTSTANDING).
REQ-019 new_request and data_in_ack1 both equal issue, combinationally, in the same cycle.
REQ-020 On issue, ea[1:0] is pushed into an in-order offset FIFO of depth MAX_OUTSTANDING.
REQ-021 count: outstanding counter with range 0..MAX_OUTSTANDING.
  - increments on issue;
  - decrements on load_complete when count > 0;
  - is unchanged when both events occur in the same cycle.
REQ-022 The full check uses the registered count; a completion in the same cycle does not free the slot until the next cycle.
REQ-023 Completions return in issue order. load_complete pops the FIFO head and selects the lane from load_data:
  - LW_BYTE: byte [8*off+7 : 8*off];
  - LW_HALF: half [16*off[1]+15 : 16*off[1]], off[0] ignored;
  - LW_WORD: the full word.
REQ-024 The selected lane is sign- or zero-extended to XLEN according to LOAD_SIGNED.
REQ-025 data_out and data_valid_out are registered: latency from load_complete to data_valid_out is exactly 1 cycle.
REQ-026 data_valid_out is 1 for exactly one cycle per completion; back-to-back completions produce back-to-back strobes.
REQ-027 data_out holds its last value when data_valid_out is 0.
REQ-028 load_complete while count == 0 is ignored: no strobe, no FIFO pop, no counter change.
REQ-029 Minimum load-to-result latency: 1 cycle plus the LSQ latency.

Reset
REQ-030 While rst is high:
  - count = 0, FIFO empty, data_out = 0, data_valid_out = 0;
  - new_request = 0 and data_in_ack1 = 0 regardless of the inputs.
REQ-031 Reset asserted mid-operation discards all outstanding offsets; load_complete responses for pre-reset requests count as count == 0 completions and are ignored per REQ-028.

Structure
REQ-032 Type load_width_t (LW_BYTE, LW_HALF, LW_WORD) belongs in rca_config; LS_W_fn3 comes from riscv_types.
REQ-033 The offset FIFO is implemented as one sub-module, load_offset_fifo, parametrised by DEPTH and WIDTH = 2.
REQ-034 The load_ou datapath is otherwise flat; the extension logic is a combinational function inside load_ou.

Verification
REQ-035 LW_BYTE, LOAD_SIGNED=1, data_in1 = 0x1001, load_data = 0x0000_8000 -> addr = 0x1000, data_out = 0xFFFF_FF80, strobe 1 cycle after load_complete.
REQ-036 LW_HALF, LOAD_SIGNED=0, ADDR_OFFSET = -2, data_in1 = 0x2004, load_data = 0x8001_1234 -> addr = 0x2000, data_out = 0x0000_8001.
REQ-037 MAX_OUTSTANDING=2, data_valid_in1 held high, no completions -> exactly 2 issues, then data_in_ack1 = 0. One completion -> a 3rd issue in the following cycle, not the same cycle.
REQ-038 Four byte loads at offsets 0..3 of word 0x44332211, completed back-to-back -> data_out = 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
REQ-039 lsq_full = 1 with data_valid_in1 = 1 -> new_request = 0, data_in_ack1 = 0, count unchanged.
REQ-040 Reset with 3 loads outstanding, then 3 late load_complete pulses -> no data_valid_out, count stays 0.

Source files
------------

// File: rtl/load_ou_pkg.sv
// Shared ISA constants and unit configuration types for the load unit.
package riscv_types;
    localparam int XLEN = 32;
    localparam logic [2:0] LS_W_fn3 = 3'b010;
endpackage

package rca_config;
    typedef enum logic [1:0] {LW_BYTE, LW_HALF, LW_WORD} load_width_t;
endpackage

// File: rtl/load_offset_fifo.sv
// In-order FIFO of byte offsets for in-flight loads. The owner guarantees no
// overflow and no pop while empty via its outstanding counter.
module load_offset_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_d = push ? next_ptr(wr_q) : wr_q;
        rd_d = pop  ? next_ptr(rd_q) : rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: equal pointers already mean empty.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_q] <= din;
    end

    assign dout = mem_q[rd_q];
endmodule

// File: rtl/load_ou.sv
// Load operation unit: forms the load address, issues to the LSQ under an
// outstanding limit, and extracts/extends the returned lane in issue order.
module load_ou
    import riscv_types::*;
    import rca_config::*;
#(
    parameter load_width_t        LOAD_WIDTH      = LW_BYTE,
    parameter int                 LOAD_SIGNED     = 0,
    parameter int                 MAX_OUTSTANDING = 4,
    parameter logic signed [11:0] ADDR_OFFSET     = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] data_in1,
    input  logic            data_valid_in1,
    input  logic [XLEN-1:0] data_in2,
    input  logic            data_valid_in2,
    output logic            data_in_ack1,
    output logic            data_in_ack2,
    output logic            uses_data_in1,
    output logic            uses_data_in2,
    output logic [XLEN-1:0] data_out,
    output logic            data_valid_out,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] data,
    output logic [2:0]      fn3,
    output logic            load,
    output logic            store,
    output logic            new_request,
    input  logic            lsq_full,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_complete
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic signed [XLEN-1:0] OFF_EXT = XLEN'(ADDR_OFFSET);

    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] data_out_q;
    logic            valid_out_q;
    logic [XLEN-1:0] ea;
    logic [1:0]      head_off;
    logic            issue, pop;
    logic            unused_inputs;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] w, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (LOAD_WIDTH)
            LW_BYTE: extend = {{(XLEN-8){(LOAD_SIGNED != 0) && b[7]}}, b};
            LW_HALF: extend = {{(XLEN-16){(LOAD_SIGNED != 0) && h[15]}}, h};
            default: extend = w;
        endcase
    endfunction

    assign ea    = data_in1 + OFF_EXT;
    assign issue = !rst && data_valid_in1 && !lsq_full && (count_q < CW'(MAX_OUTSTANDING));
    // Completions with nothing outstanding are stale (e.g. from before a reset).
    assign pop   = !rst && load_complete && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({issue, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            count_q     <= count_d;
            valid_out_q <= pop;
            if (pop) data_out_q <= extend(load_data, head_off);
        end
    end

    load_offset_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(2)) u_off_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (issue),
        .din  (ea[1:0]),
        .pop  (pop),
        .dout (head_off)
    );

    assign unused_inputs  = ^{data_in2, data_valid_in2};

    assign new_request    = issue;
    assign data_in_ack1   = issue;
    assign data_in_ack2   = 1'b0;
    assign uses_data_in1  = 1'b1;
    assign uses_data_in2  = 1'b0;
    assign addr           = {ea[XLEN-1:2], 2'b00};
    assign data           = '0;
    assign fn3            = LS_W_fn3;
    assign load           = 1'b1;
    assign store          = 1'b0;
    assign data_out       = data_out_q;
    assign data_valid_out = valid_out_q;
endmodule

// File: tb/tb_load_ou.sv
// Scoreboard bench for load_ou: two configurations (signed byte, unsigned half
// with negative offset) driven with directed vectors.
module tb_load_ou;
    import rca_config::*;

    typedef struct {
        logic [31:0] v;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    // DUT A: signed byte, depth 4, no offset
    logic        a_rst, a_vin, a_vin2, a_full, a_lc;
    logic [31:0] a_din, a_din2, a_ld;
    logic        a_ack1, a_ack2, a_use1, a_use2, a_dvo, a_load, a_store, a_nreq;
    logic [31:0] a_dout, a_addr, a_data;
    logic [2:0]  a_fn3;

    // DUT B: unsigned half, depth 2, offset -2
    logic        b_rst, b_vin, b_vin2, b_full, b_lc;
    logic [31:0] b_din, b_din2, b_ld;
    logic        b_ack1, b_ack2, b_use1, b_use2, b_dvo, b_load, b_store, b_nreq;
    logic [31:0] b_dout, b_addr, b_data;
    logic [2:0]  b_fn3;

    load_ou #(.LOAD_WIDTH(LW_BYTE), .LOAD_SIGNED(1), .MAX_OUTSTANDING(4), .ADDR_OFFSET(12'sd0)) dut_a (
        .clk(clk), .rst(a_rst), .data_in1(a_din), .data_valid_in1(a_vin),
        .data_in2(a_din2), .data_valid_in2(a_vin2), .data_in_ack1(a_ack1), .data_in_ack2(a_ack2),
        .uses_data_in1(a_use1), .uses_data_in2(a_use2), .data_out(a_dout), .data_valid_out(a_dvo),
        .addr(a_addr), .data(a_data), .fn3(a_fn3), .load(a_load), .store(a_store),
        .new_request(a_nreq), .lsq_full(a_full), .load_data(a_ld), .load_complete(a_lc)
    );

    load_ou #(.LOAD_WIDTH(LW_HALF), .LOAD_SIGNED(0), .MAX_OUTSTANDING(2), .ADDR_OFFSET(-12'sd2)) dut_b (
        .clk(clk), .rst(b_rst), .data_in1(b_din), .data_valid_in1(b_vin),
        .data_in2(b_din2), .data_valid_in2(b_vin2), .data_in_ack1(b_ack1), .data_in_ack2(b_ack2),
        .uses_data_in1(b_use1), .uses_data_in2(b_use2), .data_out(b_dout), .data_valid_out(b_dvo),
        .addr(b_addr), .data(b_data), .fn3(b_fn3), .load(b_load), .store(b_store),
        .new_request(b_nreq), .lsq_full(b_full), .load_data(b_ld), .load_complete(b_lc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] v, input int c);
        exp_t e;
        e.v = v;
        e.c = c;
        return e;
    endfunction

    // Monitors: every strobe must match the head of its queue, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (a_dvo === 1'b1) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL a_strobe: unexpected data_out=%h, expected no strobe (cycle %0d)", a_dout, cyc);
            end else begin
                e = qa.pop_front();
                if (a_dout !== e.v || cyc != e.c) begin
                    n_bad++;
                    $display("FAIL a_result: got %h at cycle %0d, expected %h at cycle %0d", a_dout, cyc, e.v, e.c);
                end
            end
        end
        if (b_dvo === 1'b1) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL b_strobe: unexpected data_out=%h, expected no strobe (cycle %0d)", b_dout, cyc);
            end else begin
                e = qb.pop_front();
                if (b_dout !== e.v || cyc != e.c) begin
                    n_bad++;
                    $display("FAIL b_result: got %h at cycle %0d, expected %h at cycle %0d", b_dout, cyc, e.v, e.c);
                end
            end
        end
    end

    initial begin
        int acks;
        {a_vin2, a_full, a_lc, a_din, a_din2, a_ld} = '0;
        {b_vin2, b_full, b_lc, b_din, b_din2, b_ld, b_vin} = '0;
        a_rst = 1'b1;
        b_rst = 1'b1;
        a_vin = 1'b1;
        a_din = 32'h0000_1001;

        // Reset: outputs cleared and requests blocked despite a valid input
        repeat (2) @(negedge clk);
        #1;
        chk("rst_new_request", {31'b0, a_nreq}, 32'h0);
        chk("rst_ack1", {31'b0, a_ack1}, 32'h0);
        chk("rst_valid_out", {31'b0, a_dvo}, 32'h0);
        chk("rst_data_out", a_dout, 32'h0);
        chk("tieoffs", {24'b0, a_ack2, a_use1, a_use2, a_load, a_store, a_fn3},
            {24'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010});
        chk("tie_data", a_data, 32'h0);
        @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;
        a_vin = 1'b0;

        // Signed byte at offset 1 of 0x00008000
        @(negedge clk);
        a_din = 32'h0000_1001;
        a_vin = 1'b1;
        #1;
        chk("a_addr_1001", a_addr, 32'h0000_1000);
        chk("a_issue", {31'b0, a_nreq}, 32'h1);
        @(negedge clk);
        a_vin = 1'b0;
        a_lc  = 1'b1;
        a_ld  = 32'h0000_8000;
        qa.push_back(mk(32'hFFFF_FF80, cyc + 1));
        @(negedge clk);
        a_lc = 1'b0;
        @(negedge clk);
        #1;
        chk("a_valid_drops", {31'b0, a_dvo}, 32'h0);
        chk("a_data_holds", a_dout, 32'hFFFF_FF80);

        // LSQ full blocks issue
        a_full = 1'b1;
        a_vin  = 1'b1;
        a_din  = 32'h0000_2000;
        #1;
        chk("a_full_new_request", {31'b0, a_nreq}, 32'h0);
        chk("a_full_ack1", {31'b0, a_ack1}, 32'h0);
        @(negedge clk);
        a_full = 1'b0;

        // Four byte loads at offsets 0..3, completed back-to-back
        for (int i = 0; i < 4; i++) begin
            a_din = 32'h0000_0100 + i;
            a_vin = 1'b1;
            #1;
            chk("a_issue_lane", {31'b0, a_ack1}, 32'h1);
            @(negedge clk);
        end
        a_vin = 1'b0;
        a_ld  = 32'h4433_2211;
        for (int i = 0; i < 4; i++) begin
            a_lc = 1'b1;
            qa.push_back(mk(32'h11 * (i + 1), cyc + 1));
            @(negedge clk);
        end
        a_lc = 1'b0;

        // Reset with 3 outstanding, then stale completions must be ignored
        for (int i = 0; i < 3; i++) begin
            a_din = 32'h0000_0200 + i;
            a_vin = 1'b1;
            @(negedge clk);
        end
        a_rst = 1'b1;
        #1;
        chk("a_midrst_new_request", {31'b0, a_nreq}, 32'h0);
        @(negedge clk);
        a_rst = 1'b0;
        a_vin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_lc = 1'b1;
            @(negedge clk);
        end
        a_lc = 1'b0;
        // Counter back at zero: exactly four issues fit before the limit
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            a_vin = 1'b1;
            #1;
            if (a_ack1 === 1'b1) acks++;
            @(negedge clk);
        end
        a_vin = 1'b0;
        chk("a_issues_after_reset", acks, 4);

        // Unsigned half, offset -2: ea 0x2002 selects the upper half
        b_din = 32'h0000_2004;
        b_vin = 1'b1;
        #1;
        chk("b_addr_2004", b_addr, 32'h0000_2000);
        @(negedge clk);
        b_vin = 1'b0;
        b_lc  = 1'b1;
        b_ld  = 32'h8001_1234;
        qb.push_back(mk(32'h0000_8001, cyc + 1));
        @(negedge clk);
        b_lc = 1'b0;

        // Outstanding limit 2; a completion frees a slot only on the next cycle
        b_din = 32'h0000_3000;
        b_vin = 1'b1;
        #1;
        chk("b_issue1", {31'b0, b_ack1}, 32'h1);
        @(negedge clk);
        #1;
        chk("b_issue2", {31'b0, b_ack1}, 32'h1);
        @(negedge clk);
        #1;
        chk("b_limit", {31'b0, b_ack1}, 32'h0);
        b_lc = 1'b1;
        b_ld = 32'h5678_ABCD;
        qb.push_back(mk(32'h0000_5678, cyc + 1));
        #1;
        chk("b_same_cycle_blocked", {31'b0, b_nreq}, 32'h0);
        @(negedge clk);
        b_lc = 1'b0;
        #1;
        chk("b_issue3", {31'b0, b_ack1}, 32'h1);
        @(negedge clk);
        b_vin = 1'b0;

        repeat (3) @(negedge clk);
        chk("a_pending_results", qa.size(), 0);
        chk("b_pending_results", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
